alu_req_driver: RTL and testbench

Issuing side of the 4-bit ALU interface. Accepts one ALU command at a time over a valid/ready request port and drives `op`/`a`/`b` into the registered ALU. It then waits a fixed number of cycles for the ALU's registered result, captures `result`/`out`, and returns them over a valid/ready response port. It sits between the lab top level (switches/keys or a test sequencer) and the ALU, and counts completed transactions for display.

---
 rtl/alu_req_driver.sv | 145 ++++++++++++++
 tb/tb_alu_req_driver.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_driver.sv
// alu_req_driver
// Issuing side of the registered 4-bit ALU. Accepts one command at a time on
// a valid/ready request port, drives it into the ALU, waits LAT cycles for the
// registered result, then returns result/carry/opcode on a valid/ready
// response port. Also counts completed response handshakes.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | ready for a new command (req_ready = 1)
// DRIVE | alu_* driven, ALU samples them on the edge leaving DRIVE
// WAIT  | counting down LAT cycles for the ALU result
// RESP  | response held on rsp_* until rsp_ready
//
// Ports:
//   clk, rst                         clock, async active-high reset
//   req_valid/req_ready              request handshake
//   req_op/req_a/req_b               command fields
//   alu_op/alu_a/alu_b               registered command to the ALU
//   alu_result/alu_out               ALU result and carry/borrow bit
//   rsp_valid/rsp_ready              response handshake
//   rsp_result/rsp_carry/rsp_op      captured response
//   busy                             state != IDLE
//   txn_cnt                          completed responses, modulo 2^CNT_W
module alu_req_driver #(
    parameter int LAT   = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [2:0]       req_op,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    output logic [2:0]       alu_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_result,
    input  logic             alu_out,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_result,
    output logic             rsp_carry,
    output logic [2:0]       rsp_op,
    output logic             busy,
    output logic [CNT_W-1:0] txn_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] wait_cnt;
    logic       accept;
    logic       capture;
    logic       rsp_hs;

    assign accept  = (state == IDLE) && req_valid;
    assign capture = (state == WAIT) && (wait_cnt == 4'd0);
    assign rsp_hs  = (state == RESP) && rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_cnt == 4'd0) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt   <= 4'd0;
            alu_op     <= 3'd0;
            alu_a      <= 4'd0;
            alu_b      <= 4'd0;
            rsp_result <= 4'd0;
            rsp_carry  <= 1'b0;
            rsp_op     <= 3'd0;
            txn_cnt    <= '0;
        end else begin
            // alu_* hold the last issued command; they are only ever
            // overwritten by the next accepted request.
            if (accept) begin
                alu_op <= req_op;
                alu_a  <= req_a;
                alu_b  <= req_b;
                rsp_op <= req_op;
            end
            if (state == DRIVE) begin
                wait_cnt <= WAIT_LOAD;
            end else if ((state == WAIT) && (wait_cnt != 4'd0)) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (capture) begin
                rsp_result <= alu_result;
                // carry is only meaningful for add/sub
                rsp_carry  <= (rsp_op == 3'b000 || rsp_op == 3'b001) ? alu_out : 1'b0;
            end
            if (rsp_hs) begin
                txn_cnt <= txn_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_alu_req_driver.sv
module tb_alu_req_driver;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // ALU behavioural model: {carry, result}; non add/sub ops drive carry = 1
    // so that the driver's masking is visible.
    function automatic logic [4:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [4:0] s;
        case (op)
            3'd0:    s = {1'b0, a} + {1'b0, b};
            3'd1:    s = {1'b0, a} + {1'b0, ~b} + 5'd1;
            3'd2:    s = {1'b1, ~a};
            3'd3:    s = {1'b1, a & b};
            3'd4:    s = {1'b1, a | b};
            3'd5:    s = {1'b1, a ^ b};
            3'd6:    s = {1'b1, 3'b000, ($signed(a) < $signed(b))};
            default: s = {1'b1, 3'b000, (a == b)};
        endcase
        return s;
    endfunction

    // ---------------- DUT 1: LAT = 1, CNT_W = 8 ----------------
    logic       rst_1 = 1'b1;
    logic       req_valid_1 = 1'b0, req_ready_1;
    logic [2:0] req_op_1 = '0;
    logic [3:0] req_a_1 = '0, req_b_1 = '0;
    logic [2:0] alu_op_1;
    logic [3:0] alu_a_1, alu_b_1, alu_result_1;
    logic       alu_out_1;
    logic       rsp_valid_1, rsp_ready_1 = 1'b1, rsp_carry_1, busy_1;
    logic [3:0] rsp_result_1;
    logic [2:0] rsp_op_1;
    logic [7:0] txn_cnt_1;
    logic [4:0] p1 = '0;

    always @(posedge clk) p1 <= alu_fn(alu_op_1, alu_a_1, alu_b_1);
    assign {alu_out_1, alu_result_1} = p1;

    alu_req_driver #(.LAT(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst_1),
        .req_valid(req_valid_1), .req_ready(req_ready_1),
        .req_op(req_op_1), .req_a(req_a_1), .req_b(req_b_1),
        .alu_op(alu_op_1), .alu_a(alu_a_1), .alu_b(alu_b_1),
        .alu_result(alu_result_1), .alu_out(alu_out_1),
        .rsp_valid(rsp_valid_1), .rsp_ready(rsp_ready_1),
        .rsp_result(rsp_result_1), .rsp_carry(rsp_carry_1), .rsp_op(rsp_op_1),
        .busy(busy_1), .txn_cnt(txn_cnt_1)
    );

    // ---------------- DUT 4: LAT = 4, CNT_W = 2 ----------------
    logic       rst_4 = 1'b1;
    logic       req_valid_4 = 1'b0, req_ready_4;
    logic [2:0] req_op_4 = '0;
    logic [3:0] req_a_4 = '0, req_b_4 = '0;
    logic [2:0] alu_op_4;
    logic [3:0] alu_a_4, alu_b_4, alu_result_4;
    logic       alu_out_4;
    logic       rsp_valid_4, rsp_ready_4 = 1'b1, rsp_carry_4, busy_4;
    logic [3:0] rsp_result_4;
    logic [2:0] rsp_op_4;
    logic [1:0] txn_cnt_4;
    logic [4:0] p4 [4] = '{default: '0};

    always @(posedge clk) begin
        p4[0] <= alu_fn(alu_op_4, alu_a_4, alu_b_4);
        p4[1] <= p4[0];
        p4[2] <= p4[1];
        p4[3] <= p4[2];
    end
    assign {alu_out_4, alu_result_4} = p4[3];

    alu_req_driver #(.LAT(4), .CNT_W(2)) dut4 (
        .clk(clk), .rst(rst_4),
        .req_valid(req_valid_4), .req_ready(req_ready_4),
        .req_op(req_op_4), .req_a(req_a_4), .req_b(req_b_4),
        .alu_op(alu_op_4), .alu_a(alu_a_4), .alu_b(alu_b_4),
        .alu_result(alu_result_4), .alu_out(alu_out_4),
        .rsp_valid(rsp_valid_4), .rsp_ready(rsp_ready_4),
        .rsp_result(rsp_result_4), .rsp_carry(rsp_carry_4), .rsp_op(rsp_op_4),
        .busy(busy_4), .txn_cnt(txn_cnt_4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One full transaction on dut1 with rsp_ready held high.
    task automatic txn1(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] er, input logic ec, input logic [7:0] ecnt);
        req_op_1 = op; req_a_1 = a; req_b_1 = b; req_valid_1 = 1'b1;
        tick();                                      // E0 accept
        req_valid_1 = 1'b0;
        check("acc_busy",      busy_1,      1);
        check("acc_req_ready", req_ready_1, 0);
        check("acc_alu_op",    alu_op_1,    op);
        check("acc_alu_a",     alu_a_1,     a);
        check("acc_alu_b",     alu_b_1,     b);
        tick();                                      // E1 ALU samples
        check("e1_rsp_valid",  rsp_valid_1, 0);
        tick();                                      // E2 capture
        check("e2_rsp_valid",  rsp_valid_1, 1);
        check("rsp_result",    rsp_result_1, er);
        check("rsp_carry",     rsp_carry_1,  ec);
        check("rsp_op",        rsp_op_1,     op);
        tick();                                      // E3 handshake
        check("hs_rsp_valid",  rsp_valid_1, 0);
        check("hs_req_ready",  req_ready_1, 1);
        check("hs_txn_cnt",    txn_cnt_1,   ecnt);
    endtask

    initial begin
        int  cyc;
        int  hs;
        int  last_acc;
        bit  acc_next;
        bit  hs_next;
        int  exp_cnt [4];

        exp_cnt = '{1, 2, 3, 0};

        // reset state
        tick();
        tick();
        check("rst_req_ready",  req_ready_1,  1);
        check("rst_busy",       busy_1,       0);
        check("rst_rsp_valid",  rsp_valid_1,  0);
        check("rst_rsp_result", rsp_result_1, 0);
        check("rst_rsp_carry",  rsp_carry_1,  0);
        check("rst_rsp_op",     rsp_op_1,     0);
        check("rst_alu",        {alu_op_1, alu_a_1, alu_b_1}, 0);
        check("rst_txn_cnt",    txn_cnt_1,    0);
        check("rst4_req_ready", req_ready_4,  1);
        rst_1 = 1'b0;
        rst_4 = 1'b0;
        tick();

        // add, add with carry, subtract, signed compare (carry masked)
        txn1(3'b000, 4'd7, 4'd3, 4'hA, 1'b0, 8'd1);
        txn1(3'b000, 4'd9, 4'd8, 4'h1, 1'b1, 8'd2);
        txn1(3'b001, 4'd3, 4'd5, 4'hE, 1'b0, 8'd3);
        txn1(3'b110, 4'd8, 4'd2, 4'h1, 1'b0, 8'd4);

        // response backpressure with a new request pending
        rsp_ready_1 = 1'b0;
        req_op_1 = 3'b011; req_a_1 = 4'hC; req_b_1 = 4'hA; req_valid_1 = 1'b1;
        tick();
        req_valid_1 = 1'b0;
        tick();
        tick();
        check("bp_rsp_valid_rise", rsp_valid_1, 1);
        req_op_1 = 3'b100; req_a_1 = 4'h1; req_b_1 = 4'h2; req_valid_1 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_rsp_valid",  rsp_valid_1,  1);
            check("bp_rsp_result", rsp_result_1, 4'h8);
            check("bp_rsp_carry",  rsp_carry_1,  0);
            check("bp_rsp_op",     rsp_op_1,     3'b011);
            check("bp_req_ready",  req_ready_1,  0);
            check("bp_alu",        {alu_op_1, alu_a_1, alu_b_1}, {3'b011, 4'hC, 4'hA});
        end
        rsp_ready_1 = 1'b1;
        tick();                                      // handshake
        check("bp_hs_rsp_valid", rsp_valid_1, 0);
        check("bp_hs_req_ready", req_ready_1, 1);
        check("bp_hs_txn_cnt",   txn_cnt_1,   8'd5);
        tick();                                      // held request accepted
        req_valid_1 = 1'b0;
        check("bp_next_busy", busy_1, 1);
        check("bp_next_alu",  {alu_op_1, alu_a_1, alu_b_1}, {3'b100, 4'h1, 4'h2});
        tick();
        tick();
        check("bp_next_valid",  rsp_valid_1,  1);
        check("bp_next_result", rsp_result_1, 4'h3);
        check("bp_next_carry",  rsp_carry_1,  0);
        tick();
        check("bp_next_cnt",    txn_cnt_1,    8'd6);

        // reset during WAIT on the LAT=4 instance
        req_op_4 = 3'b000; req_a_4 = 4'd5; req_b_4 = 4'd6; req_valid_4 = 1'b1;
        tick();                                      // accept
        req_valid_4 = 1'b0;
        tick();                                      // WAIT
        tick();
        check("mid_busy_pre", busy_4, 1);
        rst_4 = 1'b1;
        #1;
        check("mid_busy",      busy_4,      0);
        check("mid_req_ready", req_ready_4, 1);
        check("mid_alu",       {alu_op_4, alu_a_4, alu_b_4}, 0);
        check("mid_txn_cnt",   txn_cnt_4,   0);
        tick();
        rst_4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            check("mid_no_rsp", rsp_valid_4, 0);
        end
        check("mid_busy_after", busy_4, 0);

        // counter wrap and issue period, back-to-back with rsp_ready high
        req_op_4 = 3'b000; req_a_4 = 4'd1; req_b_4 = 4'd1; req_valid_4 = 1'b1;
        rsp_ready_4 = 1'b1;
        cyc = 0;
        hs = 0;
        last_acc = -1;
        while (hs < 4 && cyc < 80) begin
            acc_next = req_ready_4;
            hs_next  = rsp_valid_4;
            if (hs_next) check("wrap_result", rsp_result_4, 4'd2);
            tick();
            cyc++;
            if (acc_next) begin
                if (last_acc >= 0) check("issue_period", cyc - last_acc, 7);
                last_acc = cyc;
            end
            if (hs_next) begin
                check("wrap_cnt", txn_cnt_4, exp_cnt[hs]);
                hs++;
            end
        end
        check("wrap_handshakes", hs, 4);
        req_valid_4 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
